// File: rtl/alu_rr_sched_if.sv
// ---------------------------------------------------------------------------
// alu_rr_sched_if
// Request/response bundle between the issue masters and the shared ALU
// scheduler.
//
// Handshake rule (both channels): a transfer happens in a cycle where valid
// and ready are both high at the rising clock edge. A sender holds its
// payload stable while valid is high and ready is low.
//
// Signals:
//   req_valid[NREQ]     requester i has a pending op
//   req_ready[NREQ]     one-hot, request i accepted this cycle
//   req_op[3*NREQ]      op of requester i at [3i+2:3i]
//   req_a/req_b[W*NREQ] operands of requester i at [W*i+W-1:W*i]
//   rsp_valid/ready     response channel handshake
//   rsp_id[IDW]         requester that owns the result
//   rsp_res[W]          result
//   rsp_err             divide by zero
//   busy                scheduler is executing or holding a response
//   rsp_flags[4]        {Z,N,C,V}, only when ALU_FLAGS_EN is defined
//
// Modports: master = requesters + response consumer, slave = scheduler.
// ---------------------------------------------------------------------------
interface alu_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_res;
    logic              rsp_err;
    logic              busy;
`ifdef ALU_FLAGS_EN
    logic [3:0]        rsp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy, rsp_flags
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy, rsp_flags
    );
`else
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy
    );
`endif
endinterface

// File: rtl/alu_rr_sched.sv
// ---------------------------------------------------------------------------
// alu_rr_sched
// Shares one W-bit ALU (add/sub/inc/dec/pass/not/divide/and) between NREQ
// requesters. Requests are granted round-robin one at a time, executed in a
// registered stage and returned with the requester id.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        alu_rr_sched_if.slave (request and response channels, busy)
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Timing: request accepted in cycle k -> rsp_valid high in cycle k+2.
// With rsp_ready tied high a new grant is possible every 3 cycles.
//
// Optional feature: define ALU_FLAGS_EN to add rsp_flags = {Z,N,C,V},
// registered together with rsp_res.
// ---------------------------------------------------------------------------
module alu_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_rr_sched_if.slave      bus,
    output logic [1:0]         dbg_state
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0] last_q;      // last requester served
    logic [IDW-1:0] g_q;         // requester of the in-flight op
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;

    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_res_q;
    logic           rsp_err_q;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;

    // ---------------- round-robin search ----------------
    // Walk last+1, last+2, ... wrapping at NREQ; the first valid bit wins.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IDW'(cand);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // ready is gated by rst_n so nothing is accepted while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && grant_found && rst_n)
            bus.req_ready[grant_idx] = 1'b1;
    end

    // ---------------- ALU on captured operands ----------------
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res;
    logic         alu_err;
`ifdef ALU_FLAGS_EN
    logic [W:0]   sum, diff;   // top bit is carry / borrow
    logic         alu_c, alu_v;
`else
    logic [W-1:0] sum, diff;
`endif

    always_comb begin
        // inc/dec reuse the adder/subtractor with b forced to 1
        alu_b   = (op_q == 3'b010 || op_q == 3'b011) ? W'(1) : b_q;
`ifdef ALU_FLAGS_EN
        sum     = {1'b0, a_q} + {1'b0, alu_b};
        diff    = {1'b0, a_q} - {1'b0, alu_b};
        alu_c   = 1'b0;
        alu_v   = 1'b0;
`else
        sum     = a_q + alu_b;
        diff    = a_q - alu_b;
`endif
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            3'b000, 3'b010: begin
                alu_res = sum[W-1:0];
`ifdef ALU_FLAGS_EN
                alu_c = sum[W];
                alu_v = (a_q[W-1] == alu_b[W-1]) && (sum[W-1] != a_q[W-1]);
`endif
            end
            3'b001, 3'b011: begin
                alu_res = diff[W-1:0];
`ifdef ALU_FLAGS_EN
                alu_c = diff[W];
                alu_v = (a_q[W-1] != alu_b[W-1]) && (diff[W-1] != a_q[W-1]);
`endif
            end
            3'b100: alu_res = a_q;
            3'b101: alu_res = ~a_q;
            3'b110: begin
                if (b_q == '0) begin
                    alu_res = '1;
                    alu_err = 1'b1;
                end else begin
                    alu_res = a_q / b_q;
                end
            end
            default: alu_res = a_q & b_q;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= IDW'(NREQ - 1);
            g_q         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        g_q  <= grant_idx;
                        op_q <= bus.req_op[3*int'(grant_idx) +: 3];
                        a_q  <= bus.req_a[W*int'(grant_idx) +: W];
                        b_q  <= bus.req_b[W*int'(grant_idx) +: W];
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= g_q;
                    rsp_res_q   <= alu_res;
                    rsp_err_q   <= alu_err;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_q      <= g_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] rsp_flags_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_flags_q <= '0;
        else if (state_q == EXEC)
            rsp_flags_q <= {(alu_res == '0), alu_res[W-1], alu_c, alu_v};
    end
    assign bus.rsp_flags = rsp_flags_q;
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_sched
// Directed bench for alu_rr_sched (NREQ=4, W=32). Expected values are hand
// computed constants. Define ALU_FLAGS_EN to also check rsp_flags.
// ---------------------------------------------------------------------------
module tb_alu_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // one cycle, then sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_op[3*i +: 3] = op;
        bus.req_a[W*i +: W]  = a;
        bus.req_b[W*i +: W]  = b;
    endtask

    // One isolated transaction from requester i, starting in IDLE.
    task automatic run_one(input string tag, input int i, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input logic exp_err,
                           input logic [3:0] exp_flags);
        set_req(i, op, a, b);
        bus.req_valid    = '0;
        bus.req_valid[i] = 1'b1;
        #1;
        chk({tag, "_grant"}, 64'(bus.req_ready), 64'(1 << i));
        tick();
        // operands change after the grant: must not affect the in-flight op
        bus.req_valid = '0;
        set_req(i, ~op, ~a, ~b);
        #1;
        chk({tag, "_exec_busy"}, 64'(bus.busy), 64'(1));
        chk({tag, "_exec_ready"}, 64'(bus.req_ready), 64'(0));
        tick();
        chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(1));
        chk({tag, "_id"}, 64'(bus.rsp_id), 64'(i));
        chk({tag, "_res"}, 64'(bus.rsp_res), 64'(exp_res));
        chk({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
`ifdef ALU_FLAGS_EN
        chk({tag, "_flags"}, 64'(bus.rsp_flags), 64'(exp_flags));
`else
        if (exp_flags === 4'bxxxx) $display("unreachable");
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_idle_valid"}, 64'(bus.rsp_valid), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [6];
        ord = '{0, 1, 2, 3, 0, 1};

        // ---------------- reset ----------------
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        chk("rst_rsp_res", 64'(bus.rsp_res), 64'(0));
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(0));
        rst_n = 1'b1;

        // ---------------- single request, add wrap ----------------
        run_one("add_wrap", 2, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 4'b0010);

        // ---------------- divide ----------------
        run_one("div", 0, 3'b110, 32'd100, 32'd7, 32'd14, 1'b0, 4'b0000);
        run_one("div0", 0, 3'b110, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 4'b0100);

        // ---------------- boundaries ----------------
        run_one("add_ovf", 3, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 4'b0101);
        run_one("dec_zero", 3, 3'b011, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0, 4'b0110);

        // ---------------- ops sweep ----------------
        run_one("sw_add", 1, 3'b000, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 4'b0000);
        run_one("sw_sub", 1, 3'b001, 32'h0000_00F0, 32'h0000_0F0F, 32'hFFFF_F1E1, 1'b0, 4'b0110);
        run_one("sw_inc", 1, 3'b010, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_00F1, 1'b0, 4'b0000);
        run_one("sw_dec", 1, 3'b011, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_00EF, 1'b0, 4'b0000);
        run_one("sw_pass", 1, 3'b100, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_00F0, 1'b0, 4'b0000);
        run_one("sw_and", 1, 3'b111, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0000, 1'b0, 4'b1000);
        run_one("sw_not", 1, 3'b101, 32'h0000_00F0, 32'h0000_0F0F, 32'hFFFF_FF0F, 1'b0, 4'b0100);

        // ---------------- reset during EXEC ----------------
        for (int i = 0; i < NREQ; i++) set_req(i, 3'b000, W'(i * 16), 32'd1);
        bus.req_valid = 4'b1111;
        #1;
        // last served was requester 1, so requester 2 is next
        chk("mid_grant", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        chk("mid_state_exec", 64'(dbg_state), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
        chk("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_id", 64'(bus.rsp_id), 64'(0));
        chk("mid_rst_res", 64'(bus.rsp_res), 64'(0));
        chk("mid_rst_err", 64'(bus.rsp_err), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy), 64'(0));
        tick();
        tick();
        chk("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        rst_n = 1'b1;

        // ---------------- round robin, all valid ----------------
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk($sformatf("rr%0d_grant", n), 64'(bus.req_ready), 64'(1 << ord[n]));
            chk($sformatf("rr%0d_idle_valid", n), 64'(bus.rsp_valid), 64'(0));
            tick();
            chk($sformatf("rr%0d_exec_ready", n), 64'(bus.req_ready), 64'(0));
            tick();
            chk($sformatf("rr%0d_valid", n), 64'(bus.rsp_valid), 64'(1));
            chk($sformatf("rr%0d_id", n), 64'(bus.rsp_id), 64'(ord[n]));
            chk($sformatf("rr%0d_res", n), 64'(bus.rsp_res), 64'(ord[n] * 16 + 1));
            chk($sformatf("rr%0d_resp_ready", n), 64'(bus.req_ready), 64'(0));
            tick();
        end

        // ---------------- backpressure ----------------
        bus.rsp_ready = 1'b0;
        set_req(3, 3'b000, 32'd100, 32'd23);
        set_req(0, 3'b100, 32'd55, 32'd0);
        bus.req_valid = 4'b1001;
        #1;
        // last served was requester 1: search 2 (idle), 3 (valid)
        chk("bp_grant", 64'(bus.req_ready), 64'(4'b1000));
        tick();
        bus.req_valid = 4'b0001;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("bp%0d_valid", n), 64'(bus.rsp_valid), 64'(1));
            chk($sformatf("bp%0d_id", n), 64'(bus.rsp_id), 64'(3));
            chk($sformatf("bp%0d_res", n), 64'(bus.rsp_res), 64'(123));
            chk($sformatf("bp%0d_ready", n), 64'(bus.req_ready), 64'(0));
            chk($sformatf("bp%0d_busy", n), 64'(bus.busy), 64'(1));
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_rel_grant", 64'(bus.req_ready), 64'(4'b0001));
        chk("bp_rel_busy", 64'(bus.busy), 64'(0));
        chk("bp_rel_valid", 64'(bus.rsp_valid), 64'(0));
        tick();
        bus.req_valid = '0;
        tick();
        chk("bp_next_id", 64'(bus.rsp_id), 64'(0));
        chk("bp_next_res", 64'(bus.rsp_res), 64'(55));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_end_state", 64'(dbg_state), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Shares one 32-bit ALU datapath (add/sub/inc/dec/pass/not/divide/and) between NREQ requesters.
- Arbitration is round-robin. Each requester has a valid/ready request handshake.
- Grants one request at a time, executes it in a registered execute stage and returns the result with the requester id on a valid/ready response channel.
- Sits between the instruction-issue masters and the ALU, replacing direct en/op driving.

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 32: operand and result width.
- IDW, $clog2(NREQ): requester id width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  bit i = requester i has a pending op
- req_ready  output  NREQ  one-hot; bit i = request i accepted this cycle
- req_op  input  3*NREQ  op of requester i at [3i+2:3i]
- req_a  input  W*NREQ  operand a of requester i at [W*i+W-1:W*i]
- req_b  input  W*NREQ  operand b of requester i, same packing
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the requester that owns rsp_res
- rsp_res  output  W  result
- rsp_err  output  1  divide by zero occurred
- busy  output  1  high in EXEC or RESP

Behaviour:
- Reset: async on rst_n low, regardless of state or in-flight op.
  - State -> IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_err=0, busy=0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - An in-flight op is discarded; no response is produced for it.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching last+1, last+2, … modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle only, and only in IDLE.
  - Capture op/a/b of g and g itself into internal registers; -> EXEC.
  - With no request, stay in IDLE; req_ready=0.
- EXEC:
  - Compute on the captured operands.
  - Register rsp_res, rsp_err and rsp_id=g; set rsp_valid=1; -> RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid=0, last=g, -> IDLE.
  - No new grant is issued in the handshake cycle.
- Timing:
  - Latency: request accepted in cycle k -> rsp_valid high in cycle k+2.
  - Minimum issue interval: 3 cycles with rsp_ready tied high.
- Op encoding; all arithmetic is unsigned, modulo 2^W, carries discarded:
  - 000: a+b
  - 001: a-b
  - 010: a+1
  - 011: a-1
  - 100: a
  - 101: ~a
  - 110: a/b, unsigned quotient
  - 111: a&b
- Divide by zero (op 110 with b=0): rsp_res = all ones, rsp_err=1. rsp_err=0 for every other case.
- Request rules:
  - A requester that drops req_valid before being granted is simply skipped.
  - Requester inputs are sampled only in the grant cycle; later changes do not affect the in-flight op.
- Fairness: with all NREQ requesters valid continuously, grants rotate 0,1,…,NREQ-1,0, and no requester waits more than NREQ grants.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, adds output rsp_flags [3:0] = {Z, N, C, V}, registered with rsp_res and reset to 0:
  - Z = (rsp_res==0).
  - N = rsp_res[W-1].
  - C = carry out of add/inc, or borrow of sub/dec; 0 for other ops.
  - V = signed overflow for add/sub/inc/dec; 0 for other ops.
- When not defined: port absent, no flag logic.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 during EXEC -> all outputs 0 immediately, no response emitted; first request after release is from requester 0 when all are valid.
- Single request: requester 2 sends op=000, a=32'hFFFF_FFFF, b=2 -> req_ready[2] for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_res=1, rsp_err=0 (with ALU_FLAGS_EN: C=1).
- Divide: op=110, a=100, b=7 -> rsp_res=14. Then a=5, b=0 -> rsp_res=32'hFFFF_FFFF, rsp_err=1.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; each grant spaced exactly 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_res/rsp_id stable, req_ready stays 0, busy=1; release -> IDLE on next cycle, then next grant.
- Ops sweep: a=32'h0000_00F0, b=32'h0000_0F0F -> add 32'h0FFF, sub 32'hFFFF_F1E1, inc 32'hF1, dec 32'hEF, pass 32'hF0, not 32'hFFFF_FF0F, and 32'h0000.
